// File: rtl/pe_conv_sequencer.sv
// Convolution address sequencer: kpos-outermost loop nest, one registered beat per handshake.
// First beat two cycles after start; outputs hold while beat_valid && !beat_ready.
module pe_conv_sequencer #(
  parameter int DIM_W  = 8,
  parameter int K_W    = 4,
  parameter int COUT   = 4,
  parameter int ACT_AW = 16,
  parameter int WGT_AW = 16,
  parameter int OUT_AW = 10
) (
  input  logic              clk_0,
  input  logic              rst_n_0,
  input  logic              cfg_we_0,
  input  logic [3:0]        cfg_addr_0,
  input  logic [31:0]       cfg_wdata_0,
  output logic [31:0]       cfg_rdata_0,
  output logic              beat_valid,
  input  logic              beat_ready,
  output logic [ACT_AW-1:0] act_addr,
  output logic              act_pad,
  output logic [WGT_AW-1:0] wgt_addr,
  output logic [OUT_AW-1:0] out_addr,
  output logic              acc_first,
  output logic              beat_last
);

  localparam int SW = DIM_W + 2;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_RUN, S_PAUSE, S_DONE} state_t;
  state_t state;

  logic [K_W-1:0]   cfg_kh, cfg_kw, cfg_pad, cfg_stride;
  logic [DIM_W-1:0] cfg_in_h, cfg_in_w, cfg_out_h, cfg_out_w;
  logic             cfg_step;
  logic [K_W-1:0]   s_kh, s_kw, s_pad, s_stride;
  logic [DIM_W-1:0] s_in_h, s_in_w, s_out_h, s_out_w;
  logic             s_step;
  logic             done, cfg_err;

  // n_* name the beat that will be loaded next; outputs hold the presented one.
  logic [K_W-1:0]    n_ky, n_kx;
  logic [DIM_W-1:0]  n_oy, n_ox;
  logic [7:0]        n_kpos, cur_kpos;
  logic [OUT_AW-1:0] n_opix;
  logic              pos_last;

  logic ctrl_wr, start_req, cont_req, abort_req, abort_hit, cfg_bad;
  logic load_en, clr;
  logic ox_wrap, oy_wrap, kx_wrap, ky_wrap, pos_end, run_end;
  logic [SW-1:0]     iy, ix;
  logic              nx_pad;
  logic [ACT_AW-1:0] nx_act;
  logic              unused_wdata;

  assign unused_wdata = ^cfg_wdata_0[31:16];

  assign ctrl_wr   = cfg_we_0 && (cfg_addr_0 == 4'd0);
  assign start_req = ctrl_wr && cfg_wdata_0[0];
  assign cont_req  = ctrl_wr && cfg_wdata_0[1];
  assign abort_req = ctrl_wr && cfg_wdata_0[2];
  assign abort_hit = abort_req && (state != S_IDLE);

  assign cfg_bad = (s_kh == '0) || (s_kw == '0) || (s_in_h == '0) || (s_in_w == '0) ||
                   (s_stride == '0) || (s_out_h == '0) || (s_out_w == '0);

  assign ox_wrap = (n_ox == s_out_w - DIM_W'(1));
  assign oy_wrap = (n_oy == s_out_h - DIM_W'(1));
  assign kx_wrap = (n_kx == s_kw - K_W'(1));
  assign ky_wrap = (n_ky == s_kh - K_W'(1));
  assign pos_end = ox_wrap && oy_wrap;
  assign run_end = pos_end && kx_wrap && ky_wrap;

  assign load_en = !abort_hit &&
                   (((state == S_CHECK) && !cfg_bad) ||
                    ((state == S_RUN) && beat_ready && !beat_last && !(s_step && pos_last)) ||
                    ((state == S_PAUSE) && cont_req));
  assign clr = abort_hit || ((state == S_IDLE) && start_req);

  // Two's-complement wrap in SW bits; the sign bit flags taps left/above the image.
  always_comb begin
    iy = SW'(n_oy) * SW'(s_stride) + SW'(n_ky) - SW'(s_pad);
    ix = SW'(n_ox) * SW'(s_stride) + SW'(n_kx) - SW'(s_pad);
    nx_pad = iy[SW-1] || ix[SW-1] || (iy >= SW'(s_in_h)) || (ix >= SW'(s_in_w));
    nx_act = '0;
    if (!nx_pad)
      nx_act = ACT_AW'(iy[DIM_W-1:0]) * ACT_AW'(s_in_w) + ACT_AW'(ix[DIM_W-1:0]);
  end

  always_comb begin
    cfg_rdata_0 = '0;
    case (cfg_addr_0)
      4'd1: cfg_rdata_0 = {16'd0, cur_kpos, 4'd0, cfg_err, (state == S_PAUSE),
                           (state != S_IDLE), done};
      4'd2: cfg_rdata_0 = (32'(cfg_kh) << 8) | 32'(cfg_kw);
      4'd3: cfg_rdata_0 = (32'(cfg_in_h) << 8) | 32'(cfg_in_w);
      4'd4: cfg_rdata_0 = (32'(cfg_pad) << 4) | 32'(cfg_stride);
      4'd5: cfg_rdata_0 = (32'(cfg_out_h) << 8) | 32'(cfg_out_w);
      4'd6: cfg_rdata_0 = 32'(cfg_step);
      default: cfg_rdata_0 = '0;
    endcase
  end

  always_ff @(posedge clk_0 or negedge rst_n_0) begin
    if (!rst_n_0) begin
      state      <= S_IDLE;
      beat_valid <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
      cfg_kh     <= '0;  cfg_kw    <= '0;  cfg_pad   <= '0;  cfg_stride <= '0;
      cfg_in_h   <= '0;  cfg_in_w  <= '0;  cfg_out_h <= '0;  cfg_out_w  <= '0;
      cfg_step   <= 1'b0;
      s_kh       <= '0;  s_kw      <= '0;  s_pad     <= '0;  s_stride   <= '0;
      s_in_h     <= '0;  s_in_w    <= '0;  s_out_h   <= '0;  s_out_w    <= '0;
      s_step     <= 1'b0;
    end else begin
      if (cfg_we_0) begin
        case (cfg_addr_0)
          4'd2: begin cfg_kh <= cfg_wdata_0[8 +: K_W];    cfg_kw <= cfg_wdata_0[0 +: K_W];     end
          4'd3: begin cfg_in_h <= cfg_wdata_0[8 +: DIM_W]; cfg_in_w <= cfg_wdata_0[0 +: DIM_W]; end
          4'd4: begin cfg_pad <= cfg_wdata_0[4 +: K_W];   cfg_stride <= cfg_wdata_0[0 +: K_W]; end
          4'd5: begin cfg_out_h <= cfg_wdata_0[8 +: DIM_W]; cfg_out_w <= cfg_wdata_0[0 +: DIM_W]; end
          4'd6: cfg_step <= cfg_wdata_0[0];
          default: ;
        endcase
      end
      if (abort_hit) begin
        state      <= S_IDLE;
        beat_valid <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (start_req) begin
            done     <= 1'b0;
            s_kh     <= cfg_kh;    s_kw     <= cfg_kw;
            s_pad    <= cfg_pad;   s_stride <= cfg_stride;
            s_in_h   <= cfg_in_h;  s_in_w   <= cfg_in_w;
            s_out_h  <= cfg_out_h; s_out_w  <= cfg_out_w;
            s_step   <= cfg_step;
            state    <= S_CHECK;
          end
          S_CHECK: if (cfg_bad) begin
            cfg_err <= 1'b1;
            done    <= 1'b1;
            state   <= S_IDLE;
          end else begin
            cfg_err    <= 1'b0;
            done       <= 1'b0;
            beat_valid <= 1'b1;
            state      <= S_RUN;
          end
          S_RUN: if (beat_ready) begin
            if (beat_last) begin
              beat_valid <= 1'b0;
              state      <= S_DONE;
            end else if (s_step && pos_last) begin
              beat_valid <= 1'b0;
              state      <= S_PAUSE;
            end
          end
          S_PAUSE: if (cont_req) begin
            beat_valid <= 1'b1;
            state      <= S_RUN;
          end
          S_DONE: begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_0 or negedge rst_n_0) begin
    if (!rst_n_0) begin
      act_addr  <= '0;
      act_pad   <= 1'b0;
      wgt_addr  <= '0;
      out_addr  <= '0;
      acc_first <= 1'b0;
      beat_last <= 1'b0;
      pos_last  <= 1'b0;
      cur_kpos  <= '0;
      n_ky <= '0; n_kx <= '0; n_oy <= '0; n_ox <= '0;
      n_kpos <= '0; n_opix <= '0;
    end else if (clr) begin
      beat_last <= 1'b0;
      pos_last  <= 1'b0;
      cur_kpos  <= '0;
      n_ky <= '0; n_kx <= '0; n_oy <= '0; n_ox <= '0;
      n_kpos <= '0; n_opix <= '0;
    end else if (load_en) begin
      act_addr  <= nx_act;
      act_pad   <= nx_pad;
      wgt_addr  <= WGT_AW'(n_kpos) * WGT_AW'(COUT);
      out_addr  <= n_opix;
      acc_first <= (n_kpos == 8'd0);
      beat_last <= run_end;
      pos_last  <= pos_end;
      cur_kpos  <= n_kpos;
      n_opix    <= pos_end ? '0 : n_opix + OUT_AW'(1);
      if (!ox_wrap) n_ox <= n_ox + DIM_W'(1);
      else begin
        n_ox <= '0;
        if (!oy_wrap) n_oy <= n_oy + DIM_W'(1);
        else begin
          n_oy   <= '0;
          n_kpos <= run_end ? 8'd0 : n_kpos + 8'd1;
          if (!kx_wrap) n_kx <= n_kx + K_W'(1);
          else begin
            n_kx <= '0;
            n_ky <= ky_wrap ? '0 : n_ky + K_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_conv_sequencer.sv
// Directed bench for pe_conv_sequencer: loop-nest reference model plus hand-computed beats.
module tb_pe_conv_sequencer;

  logic        clk_0 = 1'b0;
  logic        rst_n_0, cfg_we_0, beat_ready;
  logic [3:0]  cfg_addr_0;
  logic [31:0] cfg_wdata_0, cfg_rdata_0;
  logic        beat_valid, act_pad, acc_first, beat_last;
  logic [15:0] act_addr, wgt_addr;
  logic [9:0]  out_addr;

  always #5 clk_0 = ~clk_0;

  pe_conv_sequencer dut (
    .clk_0(clk_0), .rst_n_0(rst_n_0), .cfg_we_0(cfg_we_0), .cfg_addr_0(cfg_addr_0),
    .cfg_wdata_0(cfg_wdata_0), .cfg_rdata_0(cfg_rdata_0), .beat_valid(beat_valid),
    .beat_ready(beat_ready), .act_addr(act_addr), .act_pad(act_pad), .wgt_addr(wgt_addr),
    .out_addr(out_addr), .acc_first(acc_first), .beat_last(beat_last)
  );

  typedef struct packed {
    logic [15:0] act;
    logic        pad;
    logic [15:0] wgt;
    logic [9:0]  outa;
    logic        first;
    logic        last;
  } beat_t;

  int    vectors = 0;
  int    miscompares = 0;
  beat_t got[$];
  beat_t exp_q[$];
  int    pause_at[$];
  int    pause_kpos[$];
  int    first_valid_cyc;
  int    late_resume;

  function automatic beat_t cur_beat();
    return {act_addr, act_pad, wgt_addr, out_addr, acc_first, beat_last};
  endfunction

  task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk_0);
    cfg_we_0 = 1'b1; cfg_addr_0 = a; cfg_wdata_0 = d;
    @(negedge clk_0);
    cfg_we_0 = 1'b0; cfg_addr_0 = 4'd1; cfg_wdata_0 = '0;
  endtask

  task automatic cfg_read(input logic [3:0] a, output logic [31:0] d);
    cfg_addr_0 = a;
    #1;
    d = cfg_rdata_0;
    cfg_addr_0 = 4'd1;
  endtask

  task automatic setup(input int kh, input int kw, input int inh, input int inw,
                       input int s, input int p, input int oh, input int ow, input int step);
    beat_t b;
    cfg_write(4'd2, 32'((kh << 8) | kw));
    cfg_write(4'd3, 32'((inh << 8) | inw));
    cfg_write(4'd4, 32'((p << 4) | s));
    cfg_write(4'd5, 32'((oh << 8) | ow));
    cfg_write(4'd6, 32'(step));
    exp_q.delete();
    for (int ky = 0; ky < kh; ky++)
      for (int kx = 0; kx < kw; kx++)
        for (int oy = 0; oy < oh; oy++)
          for (int ox = 0; ox < ow; ox++) begin
            int iy, ix;
            iy = oy * s + ky - p;
            ix = ox * s + kx - p;
            b.pad   = (iy < 0) || (iy >= inh) || (ix < 0) || (ix >= inw);
            b.act   = b.pad ? 16'd0 : 16'(iy * inw + ix);
            b.wgt   = 16'((ky * kw + kx) * 4);
            b.outa  = 10'(oy * ow + ox);
            b.first = (ky == 0) && (kx == 0);
            b.last  = (ky == kh - 1) && (kx == kw - 1) && (oy == oh - 1) && (ox == ow - 1);
            exp_q.push_back(b);
          end
  endtask

  // Runs until beat_last is accepted; answers every pause with a continue pulse.
  task automatic collect(input bit rand_rdy, input int max_cyc);
    bit fin, cont_sent;
    got.delete(); pause_at.delete(); pause_kpos.delete();
    first_valid_cyc = -1; late_resume = 0; fin = 0; cont_sent = 0;
    for (int c = 1; c <= max_cyc && !fin; c++) begin
      @(negedge clk_0);
      cfg_we_0 = 1'b0; cfg_addr_0 = 4'd1; cfg_wdata_0 = '0;
      #1;
      if (cont_sent && !beat_valid) late_resume++;
      cont_sent = 0;
      beat_ready = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (beat_valid && first_valid_cyc < 0) first_valid_cyc = c;
      if (beat_valid && beat_ready) begin
        got.push_back(cur_beat());
        if (beat_last) fin = 1;
      end else if (!beat_valid && cfg_rdata_0[2]) begin
        pause_at.push_back(got.size());
        pause_kpos.push_back(int'(cfg_rdata_0[15:8]));
        cfg_we_0 = 1'b1; cfg_addr_0 = 4'd0; cfg_wdata_0 = 32'd2;
        cont_sent = 1;
      end
    end
    vectors++;
    if (!fin) begin
      miscompares++;
      $display("FAIL collect_timeout: got %0d beats without beat_last, required last within %0d cycles",
               got.size(), max_cyc);
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    @(negedge clk_0); #1;
    vectors++;
    if ({beat_valid, act_addr, act_pad, wgt_addr, out_addr, acc_first, beat_last} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: valid=%b act=%h pad=%b wgt=%h out=%h first=%b last=%b, required all 0",
               beat_valid, act_addr, act_pad, wgt_addr, out_addr, acc_first, beat_last);
    end
    for (int a = 1; a <= 7; a++) begin
      cfg_read(4'(a), r);
      vectors++;
      if (r !== 32'd0) begin
        miscompares++;
        $display("FAIL reset_reg%0d: read %h, required 00000000", a, r);
      end
    end
  endtask

  task automatic test_regs();
    logic [31:0] r;
    logic [31:0] wr_d [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF};
    logic [31:0] rd_e [5] = '{32'h0000_0F0F, 32'h0000_FFFF, 32'h0000_00FF, 32'h0000_5678, 32'h0000_0001};
    for (int i = 0; i < 5; i++) begin
      cfg_write(4'(i + 2), wr_d[i]);
      cfg_read(4'(i + 2), r);
      vectors++;
      if (r !== rd_e[i]) begin
        miscompares++;
        $display("FAIL regs_rw%0d: read %h, required %h", i + 2, r, rd_e[i]);
      end
    end
    cfg_write(4'd9, 32'hDEAD_BEEF);
    cfg_read(4'd9, r);
    vectors++;
    if (r !== 32'd0) begin
      miscompares++;
      $display("FAIL regs_unmapped: read %h, required 00000000", r);
    end
  endtask

  task automatic test_basic();
    logic [31:0] r;
    setup(2, 2, 4, 4, 1, 0, 3, 3, 0);
    cfg_write(4'd0, 32'd1);
    collect(0, 200);
    vectors++;
    if (first_valid_cyc !== 1) begin
      miscompares++;
      $display("FAIL basic_latency: first valid at cycle %0d after start, required 1", first_valid_cyc);
    end
    vectors++;
    if (got.size() !== 36) begin
      miscompares++;
      $display("FAIL basic_count: %0d beats, required 36", got.size());
    end
    if (got.size() == 36) begin
      vectors++;
      if (got[0] !== {16'd0, 1'b0, 16'd0, 10'd0, 1'b1, 1'b0}) begin
        miscompares++; $display("FAIL basic_beat0: got %h required act0 wgt0 out0 first1", got[0]);
      end
      vectors++;
      if (got[9] !== {16'd1, 1'b0, 16'd4, 10'd0, 1'b0, 1'b0}) begin
        miscompares++; $display("FAIL basic_beat9: got %h required act1 wgt4 out0 first0", got[9]);
      end
      vectors++;
      if (got[35] !== {16'd15, 1'b0, 16'd12, 10'd8, 1'b0, 1'b1}) begin
        miscompares++; $display("FAIL basic_beat35: got %h required act15 wgt12 out8 last1", got[35]);
      end
      for (int i = 0; i < 36; i++) begin
        vectors++;
        if (got[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL basic_seq beat %0d: got %h required %h", i, got[i], exp_q[i]);
        end
      end
    end
    @(negedge clk_0); #1;
    vectors++;
    if (beat_valid !== 1'b0 || cfg_rdata_0[1:0] !== 2'b10) begin
      miscompares++;
      $display("FAIL basic_tail: valid=%b status[1:0]=%b, required valid 0 busy 1 done 0",
               beat_valid, cfg_rdata_0[1:0]);
    end
    @(negedge clk_0); #1;
    vectors++;
    if (cfg_rdata_0 !== 32'h0000_0301) begin
      miscompares++;
      $display("FAIL basic_status: read %h, required 00000301", cfg_rdata_0);
    end
    cfg_write(4'd0, 32'd2);
    cfg_read(4'd1, r);
    vectors++;
    if (r !== 32'h0000_0301 || beat_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_continue: status %h valid %b, required 00000301 and 0", r, beat_valid);
    end
  endtask

  task automatic test_pad();
    setup(3, 3, 4, 4, 1, 1, 4, 4, 0);
    cfg_write(4'd0, 32'd1);
    collect(0, 400);
    vectors++;
    if (got.size() !== 144) begin
      miscompares++;
      $display("FAIL pad_count: %0d beats, required 144", got.size());
    end
    if (got.size() == 144) begin
      vectors++;
      if (got[0].pad !== 1'b1 || got[0].act !== 16'd0) begin
        miscompares++; $display("FAIL pad_beat0: pad=%b act=%0d, required pad 1 act 0", got[0].pad, got[0].act);
      end
      vectors++;
      if (got[5].pad !== 1'b0 || got[5].act !== 16'd0) begin
        miscompares++; $display("FAIL pad_beat5: pad=%b act=%0d, required pad 0 act 0", got[5].pad, got[5].act);
      end
      for (int i = 0; i < 144; i++) begin
        vectors++;
        if (got[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL pad_seq beat %0d: got %h required %h", i, got[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_step();
    int want_at [3] = '{9, 18, 27};
    setup(2, 2, 4, 4, 1, 0, 3, 3, 1);
    cfg_write(4'd0, 32'd1);
    collect(0, 300);
    vectors++;
    if (pause_at.size() !== 3) begin
      miscompares++;
      $display("FAIL step_pauses: %0d pauses, required 3", pause_at.size());
    end
    for (int i = 0; i < 3 && i < pause_at.size(); i++) begin
      vectors++;
      if (pause_at[i] !== want_at[i] || pause_kpos[i] !== i) begin
        miscompares++;
        $display("FAIL step_pause%0d: after %0d beats kpos %0d, required after %0d kpos %0d",
                 i, pause_at[i], pause_kpos[i], want_at[i], i);
      end
    end
    vectors++;
    if (late_resume !== 0) begin
      miscompares++;
      $display("FAIL step_resume: %0d late resumes, required 0", late_resume);
    end
    vectors++;
    if (got.size() !== 36) begin
      miscompares++;
      $display("FAIL step_count: %0d beats, required 36", got.size());
    end
    for (int i = 0; i < 36 && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL step_seq beat %0d: got %h required %h", i, got[i], exp_q[i]);
      end
    end
    cfg_write(4'd6, 32'd0);
  endtask

  task automatic test_backpressure();
    setup(2, 2, 4, 4, 1, 0, 3, 3, 0);
    cfg_write(4'd0, 32'd1);
    collect(1, 600);
    vectors++;
    if (got.size() !== 36) begin
      miscompares++;
      $display("FAIL bp_count: %0d beats, required 36", got.size());
    end
    for (int i = 0; i < 36 && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL bp_seq beat %0d: got %h required %h", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_cfg_err();
    int vcount = 0;
    logic [3:0] st = 4'h0;
    setup(2, 0, 4, 4, 1, 0, 3, 3, 0);
    cfg_write(4'd0, 32'd1);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk_0); #1;
      if (beat_valid) vcount++;
      if (c == 2) st = cfg_rdata_0[3:0];
    end
    vectors++;
    if (st !== 4'b1001) begin
      miscompares++;
      $display("FAIL cfgerr_status: status[3:0]=%b, required 1001", st);
    end
    vectors++;
    if (vcount !== 0) begin
      miscompares++;
      $display("FAIL cfgerr_beats: %0d valid cycles, required 0", vcount);
    end
  endtask

  task automatic test_abort();
    int  acc = 0;
    bit  hit = 0;
    setup(2, 2, 4, 4, 1, 0, 3, 3, 0);
    cfg_write(4'd0, 32'd1);
    for (int c = 0; c < 60 && !hit; c++) begin
      @(negedge clk_0); #1;
      beat_ready = 1'b1;
      if (beat_valid && acc == 10) begin
        beat_ready = 1'b0;
        cfg_we_0 = 1'b1; cfg_addr_0 = 4'd0; cfg_wdata_0 = 32'd4;
        hit = 1;
      end else if (beat_valid) acc++;
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("FAIL abort_reach: only %0d beats seen, required beat 10", acc);
    end
    @(negedge clk_0);
    cfg_we_0 = 1'b0; cfg_addr_0 = 4'd1; cfg_wdata_0 = '0;
    #1;
    vectors++;
    if (beat_valid !== 1'b0 || cfg_rdata_0[3:0] !== 4'b0000) begin
      miscompares++;
      $display("FAIL abort_state: valid=%b status[3:0]=%b, required valid 0 status 0000",
               beat_valid, cfg_rdata_0[3:0]);
    end
    cfg_write(4'd0, 32'd1);
    collect(0, 200);
    vectors++;
    if (got.size() !== 36) begin
      miscompares++;
      $display("FAIL abort_replay_count: %0d beats, required 36", got.size());
    end
    for (int i = 0; i < 36 && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL abort_replay beat %0d: got %h required %h", i, got[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    rst_n_0 = 1'b0; cfg_we_0 = 1'b0; cfg_addr_0 = 4'd1; cfg_wdata_0 = '0; beat_ready = 1'b0;
    repeat (3) @(negedge clk_0);
    rst_n_0 = 1'b1;
    test_reset();
    test_regs();
    test_basic();
    test_pad();
    test_step();
    test_backpressure();
    test_cfg_err();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded 500000 time units");
    $fatal(1, "timeout");
  end

endmodule
